spi_frame_capture: RTL and testbench

- Parametrised successor to the fixed 48-bit accelerometer receive shift chain.
- Captures one SPI burst-read frame from a sensor such as the ADXL345: an optional command/header phase followed by NUM_CH channels of CH_WIDTH bits.
- Everything runs in the single clk_i domain. SPI pins are synchronised and edge-detected; nothing is clocked by SCLK or by a latch strobe.
- Frame length is checked. Each good frame is delivered on a valid/ready interface to the downstream display or processing logic.

---
 rtl/spi_frame_capture.sv | 198 +++++++++++++++++++
 tb/tb_spi_frame_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_capture.sv
// rtl/spi_frame_capture.sv - SPI burst-read frame capture with length check and valid/ready output
// All SPI pins are synchronised into clk_i; frames are committed on the chip-select rising edge.
module spi_frame_capture #(
  parameter int NUM_CH         = 3,
  parameter int CH_WIDTH       = 16,
  parameter int HDR_BITS       = 8,
  parameter int LSB_BYTE_FIRST = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sclk_i,
  input  logic                         sdo_i,
  input  logic                         cs_ni,
  output logic [NUM_CH*CH_WIDTH-1:0]   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         err_o,
  output logic [7:0]                   drop_cnt_o
);

  localparam int FRAME_BITS   = NUM_CH * CH_WIDTH;
  localparam int BYTES_PER_CH = CH_WIDTH / 8;
  localparam int MAX_CNT      = (FRAME_BITS > HDR_BITS) ? FRAME_BITS : HDR_BITS;
  localparam int CNT_W        = $clog2(MAX_CNT + 2);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    OVR
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdo_sync_q, sdo_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_rise_q, sclk_rise_d;
  logic                   cs_rise_q, cs_rise_d;
  logic                   cs_fall_q, cs_fall_d;
  logic                   sdo_bit_q, sdo_bit_d;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    commit_q, commit_d;
  logic                    err_q, err_d;
  logic [FRAME_BITS-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [7:0]              drop_q, drop_d;
  logic [FRAME_BITS-1:0]   remap_data;

  // Edge strobes are registered together with the SDO bit so they stay aligned.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_ni};
    sdo_sync_d  = {sdo_sync_q[SYNC_STAGES-2:0], sdo_i};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    sclk_rise_d = ~sclk_prev_q & sclk_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES-1];
    cs_rise_d   = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
    cs_fall_d   = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
    sdo_bit_d   = sdo_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if ((state_q != IDLE) && cs_rise_q) begin
      state_d = IDLE;
      if ((state_q == DATA) && (cnt_q == FRAME_CNT)) begin
        commit_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_q) begin
            cnt_d   = '0;
            state_d = (HDR_BITS == 0) ? DATA : HDR;
          end
        end
        HDR: begin
          if (sclk_rise_q) begin
            if (cnt_q == HDR_LAST) begin
              cnt_d   = '0;
              state_d = DATA;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        DATA: begin
          if (sclk_rise_q) begin
            if (cnt_q == FRAME_CNT) begin
              state_d = OVR;
            end else begin
              shift_d = {shift_q[FRAME_BITS-2:0], sdo_bit_q};
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
        end
        OVR: begin
          state_d = OVR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Received byte i sits at shift_q[FRAME_BITS-1-8*i -: 8]; place it in its channel slot.
  always_comb begin
    remap_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < BYTES_PER_CH; j++) begin
        if (LSB_BYTE_FIRST != 0) begin
          remap_data[k*CH_WIDTH + 8*j +: 8] =
            shift_q[FRAME_BITS-1-8*(k*BYTES_PER_CH+j) -: 8];
        end else begin
          remap_data[k*CH_WIDTH + 8*(BYTES_PER_CH-1-j) +: 8] =
            shift_q[FRAME_BITS-1-8*(k*BYTES_PER_CH+j) -: 8];
        end
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (commit_q) begin
      data_d  = remap_data;
      valid_d = 1'b1;
      if (valid_q && !ready_i && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sdo_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      sdo_bit_q   <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sdo_sync_q  <= sdo_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      sclk_rise_q <= sclk_rise_d;
      cs_rise_q   <= cs_rise_d;
      cs_fall_q   <= cs_fall_d;
      sdo_bit_q   <= sdo_bit_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_spi_frame_capture.sv
// tb/tb_spi_frame_capture.sv - directed bench for spi_frame_capture
// A default instance and a 2x24-bit, no-header, high-byte-first instance share the SPI pins.
module tb_spi_frame_capture;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sclk = 1'b1;
  logic        sdo = 1'b0;
  logic        cs_n = 1'b1;
  logic        ready = 1'b0;
  logic        ready_v = 1'b1;
  logic [47:0] data;
  logic        valid;
  logic        err;
  logic [7:0]  drop;
  logic [47:0] data_v;
  logic        valid_v;
  logic        err_v;
  logic [7:0]  drop_v;

  int          checks = 0;
  int          errors = 0;
  int          err_cycles = 0;
  int          err_v_cycles = 0;
  int          e0;
  logic [7:0]  tx [0:5];

  localparam logic [47:0] FRAME_G = 48'h9ABC_5678_1234;
  localparam logic [47:0] FRAME_A = 48'h3333_2222_1111;
  localparam logic [47:0] FRAME_B = 48'hCCCC_BBBB_AAAA;
  localparam logic [47:0] FRAME_C = 48'hF00D_DEAD_BEEF;
  localparam logic [47:0] FRAME_R = 48'h0605_0403_0201;

  always #5 clk = ~clk;

  spi_frame_capture dut (
    .clk_i(clk), .rst_ni(rst_ni), .sclk_i(sclk), .sdo_i(sdo), .cs_ni(cs_n),
    .data_o(data), .valid_o(valid), .ready_i(ready), .err_o(err), .drop_cnt_o(drop)
  );

  spi_frame_capture #(
    .NUM_CH(2), .CH_WIDTH(24), .HDR_BITS(0), .LSB_BYTE_FIRST(0), .SYNC_STAGES(2)
  ) dut_v (
    .clk_i(clk), .rst_ni(rst_ni), .sclk_i(sclk), .sdo_i(sdo), .cs_ni(cs_n),
    .data_o(data_v), .valid_o(valid_v), .ready_i(ready_v), .err_o(err_v), .drop_cnt_o(drop_v)
  );

  always @(negedge clk) begin
    if (err) err_cycles++;
    if (err_v) err_v_cycles++;
  end

  task automatic load_tx(input logic [47:0] bytes_in_order);
    for (int i = 0; i < 6; i++) tx[i] = bytes_in_order[47-8*i -: 8];
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      sdo  = b[7-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic start_frame(input int with_hdr);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    if (with_hdr != 0) send_bits(8'hB2, 8);
  endtask

  task automatic send_tx(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_bits(tx[i], 8);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 48'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (drop !== 8'h0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop); end
    checks++; if (data_v !== 48'h0) begin errors++; $display("FAIL reset_data_v: got %h expected 0", data_v); end
    checks++; if (valid_v !== 1'b0) begin errors++; $display("FAIL reset_valid_v: got %b expected 0", valid_v); end
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good_frame();
    load_tx(48'h3412_7856_BC9A);
    e0 = err_cycles;
    start_frame(1);
    send_tx(6);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL good_latency_early: valid=%b expected 0", valid); end
    checks++; if (data !== 48'h0) begin errors++; $display("FAIL good_data_early: got %h expected 0", data); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL good_latency: valid=%b expected 1", valid); end
    checks++; if (data !== FRAME_G) begin errors++; $display("FAIL good_data: got %h expected %h", data, FRAME_G); end
    repeat (7) @(negedge clk);
    checks++; if (err_cycles - e0 != 0) begin errors++; $display("FAIL good_no_err: err cycles %0d expected 0", err_cycles - e0); end
    checks++; if (drop !== 8'h0) begin errors++; $display("FAIL good_drop: got %0d expected 0", drop); end
  endtask

  task automatic test_short_frame();
    e0 = err_cycles;
    start_frame(1);
    send_tx(5);
    end_frame();
    checks++; if (err_cycles - e0 != 1) begin errors++; $display("FAIL short_err_pulse: err cycles %0d expected 1", err_cycles - e0); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL short_valid: got %b expected 1", valid); end
    checks++; if (data !== FRAME_G) begin errors++; $display("FAIL short_data: got %h expected %h", data, FRAME_G); end
  endtask

  task automatic test_long_frame();
    e0 = err_cycles;
    start_frame(1);
    send_tx(6);
    send_bits(8'h80, 1);
    end_frame();
    checks++; if (err_cycles - e0 != 1) begin errors++; $display("FAIL long_err_pulse: err cycles %0d expected 1", err_cycles - e0); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL long_valid: got %b expected 1", valid); end
    checks++; if (data !== FRAME_G) begin errors++; $display("FAIL long_data: got %h expected %h", data, FRAME_G); end
    checks++; if (drop !== 8'h0) begin errors++; $display("FAIL long_drop: got %0d expected 0", drop); end
  endtask

  task automatic test_consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b expected 0", valid); end
  endtask

  task automatic test_backpressure();
    load_tx(48'h1111_2222_3333);
    start_frame(1);
    send_tx(6);
    end_frame();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", valid); end
    checks++; if (data !== FRAME_A) begin errors++; $display("FAIL bp_first_data: got %h expected %h", data, FRAME_A); end
    checks++; if (drop !== 8'h0) begin errors++; $display("FAIL bp_first_drop: got %0d expected 0", drop); end
    load_tx(48'hAAAA_BBBB_CCCC);
    start_frame(1);
    send_tx(6);
    end_frame();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", valid); end
    checks++; if (data !== FRAME_B) begin errors++; $display("FAIL bp_second_data: got %h expected %h", data, FRAME_B); end
    checks++; if (drop !== 8'h1) begin errors++; $display("FAIL bp_drop: got %0d expected 1", drop); end
  endtask

  task automatic test_commit_with_transfer();
    load_tx(48'hEFBE_ADDE_0DF0);
    start_frame(1);
    send_tx(6);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== FRAME_B) begin errors++; $display("FAIL cwt_hold: got %h expected %h", data, FRAME_B); end
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL cwt_valid: got %b expected 1", valid); end
    checks++; if (data !== FRAME_C) begin errors++; $display("FAIL cwt_data: got %h expected %h", data, FRAME_C); end
    checks++; if (drop !== 8'h1) begin errors++; $display("FAIL cwt_drop: got %0d expected 1", drop); end
    repeat (7) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL cwt_consume: got %b expected 0", valid); end
  endtask

  task automatic test_reset_mid_frame();
    load_tx(48'h0102_0304_0506);
    start_frame(1);
    send_bits(tx[0], 8);
    send_bits(tx[1], 8);
    send_bits(tx[2], 4);
    rst_ni = 1'b0;
    @(negedge clk);
    checks++; if (data !== 48'h0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", err); end
    checks++; if (drop !== 8'h0) begin errors++; $display("FAIL mid_rst_drop: got %0d expected 0", drop); end
    rst_ni = 1'b1;
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    e0 = err_cycles;
    start_frame(1);
    send_tx(6);
    end_frame();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL after_rst_valid: got %b expected 1", valid); end
    checks++; if (data !== FRAME_R) begin errors++; $display("FAIL after_rst_data: got %h expected %h", data, FRAME_R); end
    checks++; if (drop !== 8'h0) begin errors++; $display("FAIL after_rst_drop: got %0d expected 0", drop); end
    checks++; if (err_cycles - e0 != 0) begin errors++; $display("FAIL after_rst_err: err cycles %0d expected 0", err_cycles - e0); end
  endtask

  task automatic test_variant();
    ready_v = 1'b0;
    @(negedge clk);
    e0 = err_v_cycles;
    load_tx(48'h1234_56AB_CDEF);
    start_frame(0);
    send_tx(6);
    end_frame();
    checks++; if (valid_v !== 1'b1) begin errors++; $display("FAIL var_valid: got %b expected 1", valid_v); end
    checks++; if (data_v !== 48'hABCDEF_123456) begin errors++; $display("FAIL var_data: got %h expected abcdef123456", data_v); end
    checks++; if (drop_v !== 8'h0) begin errors++; $display("FAIL var_drop: got %0d expected 0", drop_v); end
    checks++; if (err_v_cycles - e0 != 0) begin errors++; $display("FAIL var_err: err cycles %0d expected 0", err_v_cycles - e0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_consume();
    test_backpressure();
    test_commit_with_transfer();
    test_reset_mid_frame();
    test_variant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
